bcd_2of5_serializer: RTL and testbench

Sequencing controller that accepts a packed multi-digit BCD word, converts each digit to the 2-out-of-5 code with weights 7-4-2-1-0, and emits one 5-bit symbol per output handshake, most-significant digit first. It sits between a BCD producer (counter or display driver) and a 2-of-5 transmitter or checker. It owns the digit sequencing, the per-digit conversion, and the flow control on both sides.

---
 rtl/bcd_2of5_serializer_if.sv | 26 ++
 rtl/bcd_2of5_serializer.sv | 107 ++++++++++
 tb/tb_bcd_2of5_serializer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bcd_2of5_serializer_if.sv
// Handshake bundle between a BCD producer, the 2-of-5 serializer and a symbol consumer.
// The master side is the environment (producer + consumer); the slave side is the serializer.
interface bcd_2of5_serializer_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [4:0]            out_code;
    logic                  out_last;
    logic                  out_err;
    logic                  busy;
    logic [7:0]            err_cnt;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_code, out_last, out_err, busy, err_cnt
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_code, out_last, out_err, busy, err_cnt
    );
endinterface

// File: rtl/bcd_2of5_serializer.sv
// Latches a packed BCD word and emits one 7-4-2-1-0 two-out-of-five symbol per output
// handshake, most-significant digit first, counting invalid digits along the way.
module bcd_2of5_serializer #(
    parameter int DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_2of5_serializer_if.slave   bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4*DIGITS-1:0]   r_word;
    logic [4*DIGITS-1:0]   w_word_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [7:0]            r_err_cnt;
    logic [7:0]            w_err_cnt_nxt;
    logic [3:0]            w_digit;
    logic [4:0]            w_code;
    logic                  w_bad;
    logic                  w_accept;
    logic                  w_out_hs;
    logic                  w_sending;

    assign w_sending = (r_state == SEND);
    assign w_accept  = bus.in_valid && (r_state == IDLE);
    assign w_out_hs  = bus.out_ready && w_sending;
    assign w_digit   = r_word[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_code = 5'b00000;
        w_bad  = 1'b0;
        case (w_digit)
            4'd0:    w_code = 5'b11000;
            4'd1:    w_code = 5'b00011;
            4'd2:    w_code = 5'b00101;
            4'd3:    w_code = 5'b00110;
            4'd4:    w_code = 5'b01001;
            4'd5:    w_code = 5'b01010;
            4'd6:    w_code = 5'b01100;
            4'd7:    w_code = 5'b10001;
            4'd8:    w_code = 5'b10010;
            4'd9:    w_code = 5'b10100;
            default: w_bad  = 1'b1;
        endcase
    end

    // Every output is decoded from registered state, so nothing combinational leaks through.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = w_sending;
    assign bus.out_code  = w_sending ? w_code : 5'b00000;
    assign bus.out_err   = w_sending && w_bad;
    assign bus.out_last  = w_sending && (r_idx == '0);
    assign bus.busy      = w_sending;
    assign bus.err_cnt   = r_err_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_idx_nxt     = r_idx;
        w_err_cnt_nxt = r_err_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_word_nxt  = bus.in_bcd;
                    w_idx_nxt   = LAST_IDX;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_out_hs) begin
                    if (r_idx == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx - 1'b1;
                    end
                    if (w_bad && (r_err_cnt != 8'hFF)) begin
                        w_err_cnt_nxt = r_err_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_idx     <= '0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_idx     <= w_idx_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_2of5_serializer.sv
// Directed bench for the BCD to 2-of-5 serializer: a frame table plus hand-written
// sequences for stalls, held in_valid, mid-frame reset and error-counter saturation.
module tb_bcd_2of5_serializer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   errCount;

    bcd_2of5_serializer_if #(.DIGITS(4)) bus ();

    bcd_2of5_serializer #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] word;
        logic [19:0] codes;
        logic [3:0]  errs;
    } frame_vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offer a word at a negedge and return at the negedge right after the accept edge.
    task automatic applyStimulus(input logic [15:0] word);
        int waitCycles;
        waitCycles = 0;
        bus.in_bcd   = word;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=%0b, expected 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bcd   = 16'hDEAD;
    endtask

    task automatic checkSymbol(input string name, input int s, input logic [19:0] codes, input logic [3:0] errs);
        checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({name, "_code"},  32'(bus.out_code),  32'(codes[19-5*s -: 5]));
        checkOutput({name, "_last"},  32'(bus.out_last),  32'(s == 3));
        checkOutput({name, "_err"},   32'(bus.out_err),   32'(errs[3-s]));
        checkOutput({name, "_busy"},  32'(bus.busy),      32'd1);
        checkOutput({name, "_inrdy"}, 32'(bus.in_ready),  32'd0);
    endtask

    // Walks the four symbols of a frame, optionally stalling out_ready on one symbol.
    task automatic expectFrame(input string name, input logic [19:0] codes, input logic [3:0] errs,
                               input int stallSym, input int stallLen);
        for (int s = 0; s < 4; s++) begin
            if (s == stallSym) begin
                bus.out_ready = 1'b0;
                for (int k = 0; k < stallLen; k++) begin
                    checkSymbol({name, "_stall"}, s, codes, errs);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
            checkSymbol(name, s, codes, errs);
            if (errs[3-s] && errCount < 255) errCount++;
            @(negedge clk);
        end
        checkOutput({name, "_done_inrdy"}, 32'(bus.in_ready),  32'd1);
        checkOutput({name, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({name, "_errcnt"},     32'(bus.err_cnt),   32'(errCount));
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_inrdy"},  32'(bus.in_ready),  32'd1);
        checkOutput({name, "_valid"},  32'(bus.out_valid), 32'd0);
        checkOutput({name, "_code"},   32'(bus.out_code),  32'd0);
        checkOutput({name, "_last"},   32'(bus.out_last),  32'd0);
        checkOutput({name, "_err"},    32'(bus.out_err),   32'd0);
        checkOutput({name, "_busy"},   32'(bus.busy),      32'd0);
        checkOutput({name, "_errcnt"}, 32'(bus.err_cnt),   32'd0);
    endtask

    initial begin
        frame_vec_t vecs[5];
        checks   = 0;
        errors   = 0;
        errCount = 0;
        vecs[0] = '{16'h1234, {5'b00011, 5'b00101, 5'b00110, 5'b01001}, 4'b0000};
        vecs[1] = '{16'h9A0F, {5'b10100, 5'b00000, 5'b11000, 5'b00000}, 4'b0101};
        vecs[2] = '{16'h0987, {5'b11000, 5'b10100, 5'b10010, 5'b10001}, 4'b0000};
        vecs[3] = '{16'h6789, {5'b01100, 5'b10001, 5'b10010, 5'b10100}, 4'b0000};
        vecs[4] = '{16'hE0C5, {5'b00000, 5'b11000, 5'b00000, 5'b01010}, 4'b1010};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = 16'h0000;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].word);
            expectFrame($sformatf("vec%0d", v), vecs[v].codes, vecs[v].errs, -1, 0);
        end

        // Three-cycle stall on the second symbol stretches the frame to seven cycles.
        applyStimulus(16'h0987);
        expectFrame("stall0987", {5'b11000, 5'b10100, 5'b10010, 5'b10001}, 4'b0000, 1, 3);

        // Producer keeps in_valid high across the whole first frame and swaps in_bcd mid-frame.
        bus.in_bcd   = 16'h1234;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_bcd = 16'h5555;
        expectFrame("held1234", {5'b00011, 5'b00101, 5'b00110, 5'b01001}, 4'b0000, -1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expectFrame("held5555", {5'b01010, 5'b01010, 5'b01010, 5'b01010}, 4'b0000, -1, 0);

        // Asynchronous reset after the second symbol handshake of 0x6789.
        applyStimulus(16'h6789);
        checkSymbol("pre_rst0", 0, {5'b01100, 5'b10001, 5'b10010, 5'b10100}, 4'b0000);
        @(negedge clk);
        checkSymbol("pre_rst1", 1, {5'b01100, 5'b10001, 5'b10010, 5'b10100}, 4'b0000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("async_rst");
        errCount = 0;
        @(negedge clk);
        checkResetValues("held_rst");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetValues("post_rst");
        applyStimulus(16'h0001);
        expectFrame("after_rst", {5'b11000, 5'b11000, 5'b11000, 5'b00011}, 4'b0000, -1, 0);

        // Three hundred invalid digits push err_cnt into saturation.
        for (int f = 0; f < 75; f++) begin
            applyStimulus(16'hFFFF);
            expectFrame($sformatf("sat%0d", f), 20'h00000, 4'b1111, -1, 0);
        end
        checkOutput("sat_final", 32'(bus.err_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
